branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Resolves branches in EX and corrects the fetch stream. Compares each branch's actual outcome with the
//  prediction carried down the pipeline and raises a registered flush plus corrected PC. Queues predictor
//  training writes (pc, taken, target) toward the branch predictor, with a valid/ready handshake on its update port.
//  Sits between EX/MEM latch, hazard unit (flush) and branch predictor (update port).
// PARAMETERS
//  UQ_DEPTH  2   update-queue entries (power of 2, >=2)
//  CNT_W     16  width of statistics counters
// PORTS
//  CLK           in   1   clock, rising edge
//  nRST          in   1   asynchronous active-low reset
//  ex_valid      in   1   EX holds a live instruction this cycle
//  ex_branch     in   1   instruction is BEQ/BNE
//  ex_taken      in   1   actual branch outcome
//  ex_pc         in   32  word_t, PC of branch
//  ex_target     in   32  word_t, computed branch target
//  ex_ptaken     in   1   predicted taken (carried from IF)
//  ex_ptarget    in   32  word_t, predicted target (carried from IF)
//  stall         in   1   pipeline stalled; EX contents not advancing
//  upd_ready     in   1   predictor accepts an update this cycle
//  flush         out  1   squash IF/ID and ID/EX, redirect fetch
//  fix_npc       out  32  word_t, corrected PC, valid while flush=1
//  upd_valid     out  1   update entry at queue head valid
//  upd_pc        out  32  word_t, head entry branch PC
//  upd_taken     out  1   head entry outcome
//  upd_target    out  32  word_t, head entry target
//  uq_drop       out  1   pulse: incoming update lost, queue full
// BEHAVIOUR
//  - Resolve event R = ex_valid & ex_branch & ~stall & ~flush (instruction behind a flush is dead, never resolves).
//  - Mispredict M = ex_ptaken!=ex_taken | (ex_taken & ex_ptarget!=ex_target). Target compare only when taken.
//  - Flush: registered. Cycle N has R&M -> cycle N+1 flush=1, fix_npc = ex_taken ? ex_target : ex_pc+4
//    (32-bit wrap, carry discarded). flush is one-cycle pulse; deasserts N+2 unless new R&M (impossible: R masked).
//  - Stall holds: no R, no queue push; flush already asserted completes regardless of stall.
//  - FSM: RUN (flush=0) -> REDIRECT on R&M; REDIRECT (flush=1) -> RUN unconditionally next cycle.
//  - Update queue: circular FIFO, UQ_DEPTH entries, rd/wr ptrs + count. Every R pushes {ex_pc,ex_taken,ex_target}
//    (correct and mispredicted branches alike). Head shown on upd_*; pop when upd_valid & upd_ready.
//  - Full & push & pop same cycle: both happen, count unchanged, no drop. Full & push & no pop: entry
//    discarded, uq_drop=1 for one cycle, queue unchanged. Empty: upd_valid=0, upd_* hold last head data.
//  - Pointers wrap modulo UQ_DEPTH. upd_* driven combinationally from head register (zero added latency;
//    push in cycle N visible on upd_valid in N+1).
//  - Reset (any time, incl. mid-flush or queue non-empty): FSM RUN, flush=0, fix_npc=0, queue emptied,
//    upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, uq_drop=0, counters=0. In-flight entries lost.
// CONFIGURATION
//  BRU_STATS_EN defined: adds outputs br_count[CNT_W-1:0] (increments per R) and mp_count[CNT_W-1:0]
//  (increments per R&M); both saturate at all-ones, reset 0. Undefined: ports and counters absent;
//  all other behaviour identical.
// TESTING
//  1 Reset: nRST=0 mid-REDIRECT with 2 queued -> flush=0, upd_valid=0, fix_npc=0 immediately (async).
//  2 Correct taken: pc=0x40,taken=1,tgt=0x80,ptaken=1,ptgt=0x80 -> flush stays 0; next cycle upd_valid=1,
//    upd_pc=0x40,upd_taken=1,upd_target=0x80.
//  3 Mispredict not-taken: pc=0x100,taken=0,ptaken=1 -> next cycle flush=1,fix_npc=0x104; branch in EX that
//    flush cycle is ignored (no push, no second flush).
//  4 Wrong target: taken=1,tgt=0x200,ptaken=1,ptgt=0x300 -> flush=1,fix_npc=0x200. Wrap: pc=0xFFFFFFFC,taken=0,
//    ptaken=1 -> fix_npc=0x00000000.
//  5 Queue full: upd_ready=0, 3 resolves (UQ_DEPTH=2) -> third gives uq_drop=1, head still first; then
//    upd_ready=1 with simultaneous resolve while full -> pop+push, no drop, order preserved.
//  6 Stall: stall=1 with mispredicting branch in EX for 3 cycles -> no flush/push; stall=0 -> flush next cycle;
//    with BRU_STATS_EN br_count/mp_count=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution in EX: registered flush/redirect on mispredict plus a small FIFO of predictor updates.
// Optional statistics counters (br_count, mp_count) are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
   parameter int UQ_DEPTH = 2,
   parameter int CNT_W    = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_ptaken,
   input  logic [31:0] ex_ptarget,
   input  logic        stall,
   input  logic        upd_ready,
   output logic        flush,
   output logic [31:0] fix_npc,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic        upd_taken,
   output logic [31:0] upd_target,
   output logic        uq_drop
`ifdef BRU_STATS_EN
   ,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mp_count
`endif
);

   localparam int PTR_W = $clog2(UQ_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(UQ_DEPTH);

   localparam logic ST_RUN      = 1'b0;
   localparam logic ST_REDIRECT = 1'b1;

   logic        state_q, state_d;
   logic [31:0] fix_npc_q, fix_npc_d;

   logic resolve;
   logic mispredict;

   // A branch sitting behind an asserted flush is already squashed and must not resolve.
   assign resolve    = ex_valid & ex_branch & ~stall & (state_q == ST_RUN);
   assign mispredict = (ex_ptaken != ex_taken) | (ex_taken & (ex_ptarget != ex_target));

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      fix_npc_d = fix_npc_q;
      case (state_q)
         ST_RUN: begin
            if (resolve && mispredict) begin
               state_d   = ST_REDIRECT;
               fix_npc_d = ex_taken ? ex_target : ex_pc + 32'd4;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= ST_RUN;
         fix_npc_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         fix_npc_q <= fix_npc_d;
      end
   end

   assign flush   = (state_q == ST_REDIRECT);
   assign fix_npc = fix_npc_q;

   // ---------------- update queue ----------------
   logic [31:0]    pc_mem  [UQ_DEPTH];
   logic [31:0]    tgt_mem [UQ_DEPTH];
   logic           tkn_mem [UQ_DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [31:0]      last_pc_q, last_tgt_q;
   logic             last_tkn_q;
   logic             drop_q;

   logic full, empty, pop, push;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign pop   = ~empty & upd_ready;
   // A push into a full queue is allowed only when the head leaves in the same cycle.
   assign push  = resolve & (~full | pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; emptiness is tracked by count_q, and the reset-visible outputs come from last_*_q.
   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem[wr_ptr_q]  <= ex_pc;
         tgt_mem[wr_ptr_q] <= ex_target;
         tkn_mem[wr_ptr_q] <= ex_taken;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         last_pc_q  <= 32'd0;
         last_tgt_q <= 32'd0;
         last_tkn_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            last_pc_q  <= pc_mem[rd_ptr_q];
            last_tgt_q <= tgt_mem[rd_ptr_q];
            last_tkn_q <= tkn_mem[rd_ptr_q];
         end
         count_q <= count_d;
         drop_q  <= resolve & full & ~pop;
      end
   end

   // When empty the port keeps showing the most recently popped entry.
   assign upd_valid  = ~empty;
   assign upd_pc     = empty ? last_pc_q  : pc_mem[rd_ptr_q];
   assign upd_target = empty ? last_tgt_q : tgt_mem[rd_ptr_q];
   assign upd_taken  = empty ? last_tkn_q : tkn_mem[rd_ptr_q];
   assign uq_drop    = drop_q;

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         if (resolve && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (resolve && mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
   end

   assign br_count = br_cnt_q;
   assign mp_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (UQ_DEPTH=2); stats checks compile in with BRU_STATS_EN.
module tb_branch_resolve_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ex_valid, ex_branch, ex_taken, ex_ptaken, stall, upd_ready;
   logic [31:0] ex_pc, ex_target, ex_ptarget;
   logic        flush, upd_valid, upd_taken, uq_drop;
   logic [31:0] fix_npc, upd_pc, upd_target;
`ifdef BRU_STATS_EN
   logic [15:0] br_count, mp_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   branch_resolve_unit #(.UQ_DEPTH(2), .CNT_W(16)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .ex_valid   (ex_valid),
      .ex_branch  (ex_branch),
      .ex_taken   (ex_taken),
      .ex_pc      (ex_pc),
      .ex_target  (ex_target),
      .ex_ptaken  (ex_ptaken),
      .ex_ptarget (ex_ptarget),
      .stall      (stall),
      .upd_ready  (upd_ready),
      .flush      (flush),
      .fix_npc    (fix_npc),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .uq_drop    (uq_drop)
`ifdef BRU_STATS_EN
      ,
      .br_count   (br_count),
      .mp_count   (mp_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; returns 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
      ex_valid   = 1'b1;
      ex_branch  = 1'b1;
      ex_pc      = pc;
      ex_taken   = tk;
      ex_target  = tgt;
      ex_ptaken  = ptk;
      ex_ptarget = ptgt;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      step();
      step();
      nRST = 1'b1;
   endtask

   initial begin
      ex_valid = 0; ex_branch = 0; ex_taken = 0; ex_ptaken = 0; stall = 0; upd_ready = 0;
      ex_pc = 0; ex_target = 0; ex_ptarget = 0;
      do_reset();
      check("rst_flush",   {31'd0, flush},     32'd0);
      check("rst_fix_npc", fix_npc,            32'd0);
      check("rst_uvalid",  {31'd0, upd_valid}, 32'd0);
      check("rst_upc",     upd_pc,             32'd0);
      check("rst_drop",    {31'd0, uq_drop},   32'd0);

      // Correctly predicted taken branch: no flush, entry appears on update port next cycle.
      drive_br(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      step();
      ex_valid = 1'b0;
      check("ok_flush",  {31'd0, flush},     32'd0);
      check("ok_uvalid", {31'd0, upd_valid}, 32'd1);
      check("ok_upc",    upd_pc,             32'h40);
      check("ok_utaken", {31'd0, upd_taken}, 32'd1);
      check("ok_utgt",   upd_target,         32'h80);
      upd_ready = 1'b1;
      step();
      upd_ready = 1'b0;
      check("pop_uvalid", {31'd0, upd_valid}, 32'd0);
      check("pop_hold",   upd_pc,             32'h40);

      // Predicted taken, actually not taken; a mispredicting branch during the flush cycle is dead.
      drive_br(32'h100, 1'b0, 32'h140, 1'b1, 32'h140);
      step();
      check("mpnt_flush", {31'd0, flush}, 32'd1);
      check("mpnt_fix",   fix_npc,        32'h104);
      drive_br(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
      step();
      ex_valid = 1'b0;
      check("dead_flush",  {31'd0, flush}, 32'd0);
      check("dead_upc",    upd_pc,         32'h100);
      upd_ready = 1'b1;
      step();
      check("dead_nopush", {31'd0, upd_valid}, 32'd0);

      // Wrong target, then not-taken fall-through wrapping past 0xFFFFFFFC.
      drive_br(32'h10, 1'b1, 32'h200, 1'b1, 32'h300);
      step();
      ex_valid = 1'b0;
      check("tgt_flush", {31'd0, flush}, 32'd1);
      check("tgt_fix",   fix_npc,        32'h200);
      step();
      check("tgt_pulse", {31'd0, flush}, 32'd0);
      drive_br(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
      step();
      ex_valid = 1'b0;
      check("wrap_flush", {31'd0, flush}, 32'd1);
      check("wrap_fix",   fix_npc,        32'h0);
      step();
      upd_ready = 1'b0;
      check("wrap_drain", {31'd0, upd_valid}, 32'd0);

      // Queue full: third resolve is dropped; then push+pop while full preserves order.
      drive_br(32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      ex_pc = 32'h504;
      step();
      check("full_nodrop", {31'd0, uq_drop}, 32'd0);
      ex_pc = 32'h508;
      step();
      check("full_drop", {31'd0, uq_drop}, 32'd1);
      check("full_head", upd_pc,           32'h500);
      ex_pc = 32'h50C;
      upd_ready = 1'b1;
      step();
      ex_valid = 1'b0;
      check("pp_nodrop", {31'd0, uq_drop},   32'd0);
      check("pp_head1",  upd_pc,             32'h504);
      check("pp_valid",  {31'd0, upd_valid}, 32'd1);
      step();
      check("pp_head2",  upd_pc,             32'h50C);
      step();
      upd_ready = 1'b0;
      check("pp_empty",  {31'd0, upd_valid}, 32'd0);

      // Stall holds a mispredicting branch; it resolves once stall drops.
      do_reset();
      stall = 1'b1;
      drive_br(32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_flush",  {31'd0, flush},     32'd0);
         check("stall_nopush", {31'd0, upd_valid}, 32'd0);
      end
      stall = 1'b0;
      step();
      ex_valid = 1'b0;
      check("unstall_flush", {31'd0, flush},     32'd1);
      check("unstall_fix",   fix_npc,            32'h700);
      check("unstall_upc",   upd_pc,             32'h600);
      check("unstall_uval",  {31'd0, upd_valid}, 32'd1);
`ifdef BRU_STATS_EN
      check("br_count", {16'd0, br_count}, 32'd1);
      check("mp_count", {16'd0, mp_count}, 32'd1);
`endif
      step();
      check("unstall_pulse", {31'd0, flush}, 32'd0);

      // Asynchronous reset in the middle of a redirect with two entries queued.
      drive_br(32'h800, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      drive_br(32'h804, 1'b0, 32'h0, 1'b1, 32'h0);
      step();
      ex_valid = 1'b0;
      check("pre_rst_flush", {31'd0, flush}, 32'd1);
      check("pre_rst_fix",   fix_npc,        32'h808);
      #2;
      nRST = 1'b0;
      #1;
      check("arst_flush",  {31'd0, flush},     32'd0);
      check("arst_uvalid", {31'd0, upd_valid}, 32'd0);
      check("arst_fix",    fix_npc,            32'd0);
      check("arst_upc",    upd_pc,             32'd0);
      check("arst_drop",   {31'd0, uq_drop},   32'd0);
      step();
      nRST = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
